// File: rtl/mycpu_pkg.sv
// Shared definitions for the IO port block.
//   io_reg_t       : register map decoded from addr_in[2:0]
//   CTRL_* / STAT_*: bit positions inside CTRL and STATUS
//   CTRL_WR_MASK   : writable CTRL bits (timer bits only with IO_PORT_TIMER_EN)
// Optional feature macro: IO_PORT_TIMER_EN (compiles the interval timer).
package mycpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEC_W  = 3;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned STAT_W = 2;

  typedef enum logic [DEC_W-1:0] {
    REG_OUT    = 3'd0,
    REG_IN     = 3'd1,
    REG_STATUS = 3'd2,
    REG_CTRL   = 3'd3,
    REG_TCMP   = 3'd4,
    REG_TCNT   = 3'd5
  } io_reg_t;

  localparam int unsigned CTRL_TEN    = 0;
  localparam int unsigned CTRL_ARL    = 1;
  localparam int unsigned CTRL_IE_IN  = 2;
  localparam int unsigned CTRL_IE_TMR = 3;

  localparam int unsigned STAT_IN_CHG  = 0;
  localparam int unsigned STAT_TMR_HIT = 1;

`ifdef IO_PORT_TIMER_EN
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 4'hF;
`else
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 4'hC;
`endif

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous inputs, parameterised width.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_d        : asynchronous input
//   o_q1       : first stage (metastability catcher)
//   o_q2       : second stage (safe to use)
module io_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q1,
  output logic [W-1:0] o_q2
);

  logic [W-1:0] r_q1;
  logic [W-1:0] r_q2;

  // Synchroniser stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q1 = r_q1;
  assign o_q2 = r_q2;

endmodule

// File: rtl/io_port.sv
// Memory-mapped IO port: output latch, synchronised input, change/timer
// status with clear-on-read, interrupt request and optional interval timer.
// Optional feature macro: IO_PORT_TIMER_EN (TCMP/TCNT and CTRL[1:0]).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   iom_in     : IO cycle strobe
//   wen_in     : 0 = write, 1 = read
//   addr_in    : register address, [2:0] decoded
//   data_in    : write data
//   data_out   : combinational read data (0 outside read cycles)
//   pin_in     : asynchronous external inputs
//   pin_out    : registered external outputs
//   irq_out    : level interrupt request, combinational from registers
module io_port
  import mycpu_pkg::*;
#(
  parameter int unsigned PIN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iom_in,
  input  logic              wen_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [PIN_W-1:0]  pin_in,
  output logic [PIN_W-1:0]  pin_out,
  output logic              irq_out
);

  localparam logic [1:0] WARM_DONE = 2'd2;

  logic              w_wr;
  logic              w_rd;
  io_reg_t           w_sel;
  logic [PIN_W-1:0]  w_s1;
  logic [PIN_W-1:0]  w_s2;
  logic              w_in_chg_set;
  logic              w_tmr_hit_set;
  logic              w_unused;

  logic [PIN_W-1:0]  r_out;
  logic [PIN_W-1:0]  w_out_nxt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic [STAT_W-1:0] r_status;
  logic [STAT_W-1:0] w_status_nxt;
  logic [1:0]        r_warm;

`ifdef IO_PORT_TIMER_EN
  logic [DATA_W-1:0] r_tcmp;
  logic [DATA_W-1:0] w_tcmp_nxt;
  logic [DATA_W-1:0] r_tcnt;
  logic [DATA_W-1:0] w_tcnt_nxt;
`endif

  assign w_wr  = iom_in & ~wen_in;
  assign w_rd  = iom_in & wen_in;
  assign w_sel = io_reg_t'(addr_in[DEC_W-1:0]);

  // Upper address bits alias; data_in bits beyond used fields are ignored
  assign w_unused = ^{addr_in[DATA_W-1:DEC_W], data_in};

  io_sync2 #(
    .W (PIN_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pin_in),
    .o_q1  (w_s1),
    .o_q2  (w_s2)
  );

  // Counts the first two edges after reset so the synchroniser fill-in
  // is not reported as an input change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm <= '0;
    end else if (r_warm != WARM_DONE) begin
      r_warm <= r_warm + 2'd1;
    end
  end

  // Next-state logic for all registers
  always_comb begin
    w_out_nxt     = r_out;
    w_ctrl_nxt    = r_ctrl;
    w_status_nxt  = r_status;
    w_tmr_hit_set = 1'b0;
    // Second stage is about to load a value different from its current one
    w_in_chg_set  = (r_warm == WARM_DONE) && (w_s1 != w_s2);

`ifdef IO_PORT_TIMER_EN
    w_tcmp_nxt = r_tcmp;
    w_tcnt_nxt = r_tcnt;
    if (r_ctrl[CTRL_TEN]) begin
      if (r_tcnt == r_tcmp) begin
        w_tmr_hit_set = 1'b1;
        w_tcnt_nxt    = '0;
        if (!r_ctrl[CTRL_ARL]) begin
          w_ctrl_nxt[CTRL_TEN] = 1'b0;
        end
      end else begin
        w_tcnt_nxt = r_tcnt + 16'd1;
      end
    end
`endif

    // Clear-on-read first so that same-cycle set events win
    if (w_rd && (w_sel == REG_STATUS)) begin
      w_status_nxt = '0;
    end
    if (w_in_chg_set) begin
      w_status_nxt[STAT_IN_CHG] = 1'b1;
    end
    if (w_tmr_hit_set) begin
      w_status_nxt[STAT_TMR_HIT] = 1'b1;
    end

    // Register writes override timer-driven updates
    if (w_wr) begin
      case (w_sel)
        REG_OUT:  w_out_nxt  = data_in[PIN_W-1:0];
        REG_CTRL: w_ctrl_nxt = data_in[CTRL_W-1:0] & CTRL_WR_MASK;
`ifdef IO_PORT_TIMER_EN
        REG_TCMP: w_tcmp_nxt = data_in;
        REG_TCNT: w_tcnt_nxt = data_in;
`endif
        default:  ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_ctrl   <= '0;
      r_status <= '0;
`ifdef IO_PORT_TIMER_EN
      r_tcmp   <= '0;
      r_tcnt   <= '0;
`endif
    end else begin
      r_out    <= w_out_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_status <= w_status_nxt;
`ifdef IO_PORT_TIMER_EN
      r_tcmp   <= w_tcmp_nxt;
      r_tcnt   <= w_tcnt_nxt;
`endif
    end
  end

  // Zero-latency read mux
  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (w_sel)
        REG_OUT:    data_out = DATA_W'(r_out);
        REG_IN:     data_out = DATA_W'(w_s2);
        REG_STATUS: data_out = DATA_W'(r_status);
        REG_CTRL:   data_out = DATA_W'(r_ctrl);
`ifdef IO_PORT_TIMER_EN
        REG_TCMP:   data_out = r_tcmp;
        REG_TCNT:   data_out = r_tcnt;
`endif
        default:    data_out = '0;
      endcase
    end
  end

  assign pin_out = r_out;
  assign irq_out = (r_status[STAT_IN_CHG]  & r_ctrl[CTRL_IE_IN]) |
                   (r_status[STAT_TMR_HIT] & r_ctrl[CTRL_IE_TMR]);

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port (default PIN_W = 16).
// Inputs change on the falling edge; outputs are sampled in the low phase.
module tb_io_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iom_in;
  logic        wen_in;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] pin_in;
  logic [15:0] pin_out;
  logic        irq_out;

  int n_assert = 0;
  int n_fail   = 0;

  io_port #(
    .PIN_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iom_in   (iom_in),
    .wen_in   (wen_in),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .irq_out  (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iom_in  = 1'b0;
    wen_in  = 1'b1;
    addr_in = 16'h0000;
    data_in = 16'h0000;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    iom_in  = 1'b1;
    wen_in  = 1'b0;
    addr_in = a;
    data_in = d;
    tick(1);
    idle();
  endtask

  // Combinational read with the strobe dropped before the next edge
  task automatic peek(input logic [15:0] a, input logic [15:0] exp, input string tag);
    iom_in  = 1'b1;
    wen_in  = 1'b1;
    addr_in = a;
    #1;
    check(tag, data_out, exp);
    idle();
  endtask

  // Read held through a clock edge (clear-on-read takes effect)
  task automatic rd_edge(input logic [15:0] a, input logic [15:0] exp, input string tag);
    iom_in  = 1'b1;
    wen_in  = 1'b1;
    addr_in = a;
    #1;
    check(tag, data_out, exp);
    tick(1);
    idle();
  endtask

  initial begin
    rst_n  = 1'b1;
    pin_in = 16'h0000;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("rst_pin_out", pin_out, 16'h0000);
    check("rst_irq", 16'(irq_out), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    peek(16'h0000, 16'h0000, "rst_out_reg");
    peek(16'h0002, 16'h0000, "rst_status");

    // Output latch write and readback
    iom_in  = 1'b1;
    wen_in  = 1'b0;
    addr_in = 16'h0000;
    data_in = 16'hA5A5;
    #1;
    check("out_before_edge", pin_out, 16'h0000);
    tick(1);
    idle();
    check("out_pin", pin_out, 16'hA5A5);
    peek(16'h0000, 16'hA5A5, "out_read");
    peek(16'h0008, 16'hA5A5, "out_alias");
    iom_in  = 1'b0;
    wen_in  = 1'b1;
    #1;
    check("idle_data_out", data_out, 16'h0000);

    // Write data ignored without the IO strobe
    iom_in  = 1'b0;
    wen_in  = 1'b0;
    data_in = 16'h1234;
    tick(1);
    idle();
    check("no_iom_write", pin_out, 16'hA5A5);

    // Reserved addresses
    wr(16'h0006, 16'hFFFF);
    peek(16'h0006, 16'h0000, "rsvd6");
    peek(16'h0007, 16'h0000, "rsvd7");

    // Input synchroniser and change flag
    pin_in = 16'h0001;
    tick(1);
    peek(16'h0001, 16'h0000, "in_stage1");
    peek(16'h0002, 16'h0000, "stat_stage1");
    tick(1);
    peek(16'h0001, 16'h0001, "in_stage2");
    peek(16'h0002, 16'h0001, "stat_in_chg");
    check("irq_masked", 16'(irq_out), 16'h0000);
    wr(16'h0003, 16'h0004);
    check("irq_in_chg", 16'(irq_out), 16'h0001);
    peek(16'h0003, 16'h0004, "ctrl_ie_in");
    rd_edge(16'h0002, 16'h0001, "stat_rd");
    peek(16'h0002, 16'h0000, "stat_cleared");
    check("irq_cleared", 16'(irq_out), 16'h0000);

    // Change event on the same edge as a STATUS read keeps the flag
    pin_in = 16'h0003;
    tick(1);
    rd_edge(16'h0002, 16'h0000, "stat_race_rd");
    peek(16'h0002, 16'h0001, "stat_race_set");
    check("irq_race", 16'(irq_out), 16'h0001);
    rd_edge(16'h0002, 16'h0001, "stat_race_clr");
    peek(16'h0002, 16'h0000, "stat_race_zero");

`ifdef IO_PORT_TIMER_EN
    // One-shot compare: TCMP=3, ten+ie_tmr
    wr(16'h0004, 16'h0003);
    wr(16'h0003, 16'h0009);
    tick(3);
    peek(16'h0005, 16'h0003, "tmr_cnt3");
    check("tmr_irq_pre", 16'(irq_out), 16'h0000);
    tick(1);
    check("tmr_irq", 16'(irq_out), 16'h0001);
    peek(16'h0002, 16'h0002, "tmr_status");
    peek(16'h0003, 16'h0008, "tmr_ten_clr");
    peek(16'h0005, 16'h0000, "tmr_cnt_reload");
    tick(1);
    peek(16'h0005, 16'h0000, "tmr_stopped");
    rd_edge(16'h0002, 16'h0002, "tmr_stat_rd");
    peek(16'h0002, 16'h0000, "tmr_stat_clr");

    // Auto-reload with wrap: TCNT=FFFF, TCMP=1, ten+arl
    wr(16'h0004, 16'h0001);
    wr(16'h0005, 16'hFFFF);
    wr(16'h0003, 16'h0003);
    peek(16'h0005, 16'hFFFF, "arl_cnt_ffff");
    tick(1);
    peek(16'h0005, 16'h0000, "arl_wrap");
    tick(1);
    peek(16'h0005, 16'h0001, "arl_cnt1");
    tick(1);
    peek(16'h0005, 16'h0000, "arl_reload");
    peek(16'h0002, 16'h0002, "arl_hit");
    peek(16'h0003, 16'h0003, "arl_ten_kept");
    tick(1);
    peek(16'h0005, 16'h0001, "arl_cnt_again");
    wr(16'h0003, 16'h0000);
    rd_edge(16'h0002, 16'h0002, "arl_stat_rd");
    peek(16'h0002, 16'h0000, "arl_stat_clr");

    // Timer hit on the same edge as a STATUS read
    wr(16'h0004, 16'h0002);
    wr(16'h0003, 16'h0001);
    tick(2);
    rd_edge(16'h0002, 16'h0000, "hit_race_rd");
    peek(16'h0002, 16'h0002, "hit_race_set");
    peek(16'h0003, 16'h0000, "hit_race_ten");
    peek(16'h0005, 16'h0000, "hit_race_cnt");
    rd_edge(16'h0002, 16'h0002, "hit_race_clr");

    // TCNT write beats increment
    wr(16'h0004, 16'h0005);
    wr(16'h0003, 16'h0001);
    tick(1);
    wr(16'h0005, 16'h0100);
    peek(16'h0005, 16'h0100, "tcnt_wr_prio");
    tick(1);
    peek(16'h0005, 16'h0101, "tcnt_after_wr");
    wr(16'h0003, 16'h0000);
    wr(16'h0005, 16'h0000);
    wr(16'h0004, 16'hFFFF);
`else
    // Timer absent: registers read 0, no tmr_hit
    wr(16'h0004, 16'h1234);
    wr(16'h0005, 16'h5678);
    wr(16'h0003, 16'hFFFF);
    tick(3);
    peek(16'h0004, 16'h0000, "notmr_tcmp");
    peek(16'h0005, 16'h0000, "notmr_tcnt");
    peek(16'h0003, 16'h000C, "notmr_ctrl");
    peek(16'h0002, 16'h0000, "notmr_status");
`endif

    // Asynchronous reset in the middle of activity
    wr(16'h0003, 16'h000D);
    pin_in = 16'h0007;
    tick(2);
    check("pre_rst_irq", 16'(irq_out), 16'h0001);
`ifdef IO_PORT_TIMER_EN
    peek(16'h0005, 16'h0002, "pre_rst_tcnt");
`endif
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pin_out", pin_out, 16'h0000);
    check("mid_rst_irq", 16'(irq_out), 16'h0000);
    @(negedge clk);
    peek(16'h0000, 16'h0000, "mid_rst_out");
    peek(16'h0003, 16'h0000, "mid_rst_ctrl");
`ifdef IO_PORT_TIMER_EN
    peek(16'h0005, 16'h0000, "mid_rst_tcnt");
`endif
    rst_n = 1'b1;
    tick(3);
    peek(16'h0002, 16'h0000, "warm_suppress");
    peek(16'h0001, 16'h0007, "warm_in");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
